// File: rtl/combat_scheduler.sv
// combat_scheduler: per-player combat sequencer for the two-fighter game.
// Turns attack/defend buttons into frame-paced windup/active/recover
// phases, arbitrates attacks toward the hit judge, and applies the judge's
// hurt responses to HP, stun, KO and the winner.
`timescale 1ns/1ps
module combat_scheduler #(
  parameter int WINDUP_FRAMES  = 4,
  parameter int ACTIVE_FRAMES  = 3,
  parameter int RECOVER_FRAMES = 6,
  parameter int STUN_FRAMES    = 10,
  parameter int HP_MAX         = 100,
  parameter int DAMAGE         = 10
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic       restart,
  input  logic       atk_btn1,
  input  logic       atk_btn2,
  input  logic       def_btn1,
  input  logic       def_btn2,
  input  logic       hurt1,
  input  logic       hurt2,
  output logic       attack1,
  output logic       attack2,
  output logic       defend1,
  output logic       defend2,
  output logic [6:0] hp1,
  output logic [6:0] hp2,
  output logic [2:0] state1,
  output logic [2:0] state2,
  output logic       game_over,
  output logic [1:0] winner
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WINDUP  = 3'd1,
    ACTIVE  = 3'd2,
    RECOVER = 3'd3,
    STUN    = 3'd4,
    KO      = 3'd5
  } state_t;

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] WINDUP_LD  = CNT_W'(WINDUP_FRAMES - 1);
  localparam logic [CNT_W-1:0] ACTIVE_LD  = CNT_W'(ACTIVE_FRAMES - 1);
  localparam logic [CNT_W-1:0] RECOVER_LD = CNT_W'(RECOVER_FRAMES - 1);
  localparam logic [CNT_W-1:0] STUN_LD    = CNT_W'(STUN_FRAMES - 1);
  localparam logic [6:0]       HP_INIT    = 7'(HP_MAX);
  localparam logic [6:0]       DMG        = 7'(DAMAGE);

  // Index 0 is player1, index 1 is player2.
  state_t           st_q  [2];
  state_t           st_d  [2];
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];
  logic [6:0]       hp_q  [2];
  logic [6:0]       hp_d  [2];
  logic [1:0]       hd_q, hd_d;    // hit_done per player
  logic [1:0]       def_q, def_d;  // defend button sampled at the last tick
  logic             prio_q, prio_d; // 0: player1 has priority, 1: player2
  logic             go_q, go_d;
  logic [1:0]       win_q, win_d;

  logic [1:0] atk_btn, def_btn, hurt, qual, atk, dfd;

  assign atk_btn = {atk_btn2, atk_btn1};
  assign def_btn = {def_btn2, def_btn1};
  assign hurt    = {hurt2, hurt1};

  // HP after one hit, floored at zero.
  function automatic logic [6:0] sat_sub(input logic [6:0] hp);
    return (hp >= DMG) ? (hp - DMG) : 7'd0;
  endfunction

  // Attack qualification and arbitration: only one attack reaches the judge.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      qual[i] = (st_q[i] == ACTIVE) && !hd_q[i] && !go_q;
      dfd[i]  = (st_q[i] == IDLE) && def_q[i] && !go_q;
    end
    atk[0] = qual[0] && (!qual[1] || !prio_q);
    atk[1] = qual[1] && (!qual[0] ||  prio_q);
  end

  assign attack1   = atk[0];
  assign attack2   = atk[1];
  assign defend1   = dfd[0];
  assign defend2   = dfd[1];
  assign hp1       = hp_q[0];
  assign hp2       = hp_q[1];
  assign state1    = st_q[0];
  assign state2    = st_q[1];
  assign game_over = go_q;
  assign winner    = win_q;

  // Next-state: phase timing, hit registration, KO freeze and restart.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      st_d[i]  = st_q[i];
      cnt_d[i] = cnt_q[i];
      hp_d[i]  = hp_q[i];
    end
    hd_d   = hd_q;
    def_d  = def_q;
    prio_d = prio_q;
    go_d   = go_q;
    win_d  = win_q;

    if (frame_tick && !go_q) begin
      def_d = def_btn;
      for (int i = 0; i < 2; i++) begin
        case (st_q[i])
          IDLE: begin
            if (atk_btn[i]) begin
              st_d[i]  = WINDUP;
              cnt_d[i] = WINDUP_LD;
            end
          end
          WINDUP: begin
            if (cnt_q[i] == '0) begin
              st_d[i]  = ACTIVE;
              cnt_d[i] = ACTIVE_LD;
              hd_d[i]  = 1'b0;
            end else begin
              cnt_d[i] = cnt_q[i] - 1'b1;
            end
          end
          ACTIVE: begin
            if (cnt_q[i] == '0) begin
              st_d[i]  = RECOVER;
              cnt_d[i] = RECOVER_LD;
            end else begin
              cnt_d[i] = cnt_q[i] - 1'b1;
            end
          end
          RECOVER, STUN: begin
            if (cnt_q[i] == '0) st_d[i] = IDLE;
            else                cnt_d[i] = cnt_q[i] - 1'b1;
          end
          default: ;
        endcase
      end

      if (&qual) prio_d = ~prio_q;

      // y is the victim; arbitration guarantees at most one hit per tick.
      for (int y = 0; y < 2; y++) begin
        if (atk[1-y] && hurt[y]) begin
          hd_d[1-y] = 1'b1;
          hp_d[y]   = sat_sub(hp_q[y]);
          if (sat_sub(hp_q[y]) == 7'd0) begin
            st_d[y]  = KO;
            cnt_d[y] = '0;
            go_d     = 1'b1;
            win_d    = (y == 1) ? 2'd1 : 2'd2;
          end else begin
            st_d[y]  = STUN;
            cnt_d[y] = STUN_LD;
          end
        end
      end
    end

    if (restart) begin
      for (int i = 0; i < 2; i++) begin
        st_d[i]  = IDLE;
        cnt_d[i] = '0;
        hp_d[i]  = HP_INIT;
      end
      hd_d   = '0;
      def_d  = '0;
      prio_d = 1'b0;
      go_d   = 1'b0;
      win_d  = 2'd0;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < 2; i++) begin
        st_q[i]  <= IDLE;
        cnt_q[i] <= '0;
        hp_q[i]  <= HP_INIT;
      end
      hd_q   <= '0;
      def_q  <= '0;
      prio_q <= 1'b0;
      go_q   <= 1'b0;
      win_q  <= 2'd0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        st_q[i]  <= st_d[i];
        cnt_q[i] <= cnt_d[i];
        hp_q[i]  <= hp_d[i];
      end
      hd_q   <= hd_d;
      def_q  <= def_d;
      prio_q <= prio_d;
      go_q   <= go_d;
      win_q  <= win_d;
    end
  end

endmodule
